// File: rtl/store_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : store_port_arbiter
// Description : Round-robin arbiter sharing one data-memory write port between
//               NUM_REQ buffered store requesters. Optional stall counter is
//               enabled by defining STORE_PORT_ARB_STALL_CNT_EN.
// Revision    : 1.0
// ============================================================================
module store_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*32-1:0]   i_req_data,
    input  logic [NUM_REQ*4-1:0]    i_req_we,
    output logic                    o_mem_valid,
    input  logic                    i_mem_ready,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [31:0]             o_mem_data,
    output logic [3:0]              o_mem_we,
    output logic [ID_W-1:0]         o_mem_id,
    output logic [31:0]             o_stall_cnt
);

    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] w_pending_nxt;
    logic [NUM_REQ-1:0] r_ready;
    logic [NUM_REQ-1:0] w_capture;
    logic [ADDR_W-1:0]  r_hold_addr [NUM_REQ];
    logic [31:0]        r_hold_data [NUM_REQ];
    logic [3:0]         r_hold_we   [NUM_REQ];
    logic [ID_W-1:0]    r_ptr;

    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [31:0]        w_win_data;
    logic [3:0]         w_win_we;
    logic               w_free;
    logic               w_load;

    logic               r_mem_valid;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_data;
    logic [3:0]         r_mem_we;
    logic [ID_W-1:0]    r_mem_id;

    // Zero byte-enable stores are handshaken but never buffered.
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_req
            assign w_capture[g] = i_req_valid[g] & r_ready[g]
                                & (|i_req_we[g*4 +: 4]);

            always_ff @(posedge clk) begin
                if (w_capture[g]) begin
                    r_hold_addr[g] <= i_req_addr[g*ADDR_W +: ADDR_W];
                    r_hold_data[g] <= i_req_data[g*32 +: 32];
                    r_hold_we[g]   <= i_req_we[g*4 +: 4];
                end
            end
        end
    endgenerate

    // Two ascending scans: first from ptr upwards, then wrap to indices below ptr.
    always_comb begin
        w_found    = 1'b0;
        w_win_id   = '0;
        w_win_addr = '0;
        w_win_data = '0;
        w_win_we   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && r_pending[k] && (ID_W'(k) >= r_ptr)) begin
                w_found    = 1'b1;
                w_win_id   = ID_W'(k);
                w_win_addr = r_hold_addr[k];
                w_win_data = r_hold_data[k];
                w_win_we   = r_hold_we[k];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && r_pending[k] && (ID_W'(k) < r_ptr)) begin
                w_found    = 1'b1;
                w_win_id   = ID_W'(k);
                w_win_addr = r_hold_addr[k];
                w_win_data = r_hold_data[k];
                w_win_we   = r_hold_we[k];
            end
        end
    end

    assign w_free = ~r_mem_valid | i_mem_ready;
    assign w_load = w_free & w_found;

    always_comb begin
        w_pending_nxt = r_pending;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_load && (w_win_id == ID_W'(k))) begin
                w_pending_nxt[k] = 1'b0;
            end
            if (w_capture[k]) begin
                w_pending_nxt[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_ready     <= '1;
            r_ptr       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_we    <= '0;
            r_mem_id    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_ready   <= ~w_pending_nxt;
            if (w_load) begin
                r_ptr       <= (w_win_id == c_LAST_ID) ? '0 : w_win_id + ID_W'(1);
                r_mem_valid <= 1'b1;
                r_mem_addr  <= w_win_addr;
                r_mem_data  <= w_win_data;
                r_mem_we    <= w_win_we;
                r_mem_id    <= w_win_id;
            end else if (w_free) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    assign o_req_ready = r_ready;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_mem_we    = r_mem_we;
    assign o_mem_id    = r_mem_id;

`ifdef STORE_PORT_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_mem_valid && !i_mem_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_port_arbiter
// Description : Directed and random stimulus for store_port_arbiter, checked
//               against a queue-free behavioural model of the arbitration rules.
// Revision    : 1.0
// ============================================================================
module tb_store_port_arbiter;

    localparam int NR = 4;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_data;
    logic [NR*4-1:0]  req_we;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_data;
    logic [3:0]    mem_we;
    logic [2:0]    mem_id;
    logic [31:0]   stall_cnt;

    store_port_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .ID_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_req_we    (req_we),
        .o_mem_valid (mem_valid),
        .i_mem_ready (mem_ready),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_data),
        .o_mem_we    (mem_we),
        .o_mem_id    (mem_id),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: one buffered store per requester plus the output beat.
    bit          m_pend [NR];
    logic [31:0] m_addr [NR];
    logic [31:0] m_data [NR];
    logic [3:0]  m_we   [NR];
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_oaddr, m_odata;
    logic [3:0]  m_owe;
    int          m_oid;
    logic [31:0] m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit acc [NR];
        int win;
        if (reset) begin
            for (int k = 0; k < NR; k++) m_pend[k] = 1'b0;
            m_ptr   = 0;
            m_valid = 1'b0;
            m_oaddr = '0;
            m_odata = '0;
            m_owe   = '0;
            m_oid   = 0;
            m_stall = '0;
        end else begin
            for (int k = 0; k < NR; k++) acc[k] = req_valid[k] && !m_pend[k];
            if (m_valid && !mem_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (!m_valid || mem_ready) begin
                win = -1;
                for (int i = 0; i < NR; i++) begin
                    if (win < 0 && m_pend[(m_ptr + i) % NR]) win = (m_ptr + i) % NR;
                end
                if (win >= 0) begin
                    m_valid   = 1'b1;
                    m_oaddr   = m_addr[win];
                    m_odata   = m_data[win];
                    m_owe     = m_we[win];
                    m_oid     = win;
                    m_pend[win] = 1'b0;
                    m_ptr     = (win + 1) % NR;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int k = 0; k < NR; k++) begin
                if (acc[k] && req_we[k*4 +: 4] != 4'b0000) begin
                    m_pend[k] = 1'b1;
                    m_addr[k] = req_addr[k*32 +: 32];
                    m_data[k] = req_data[k*32 +: 32];
                    m_we[k]   = req_we[k*4 +: 4];
                end
            end
        end
    endtask

    task automatic step();
        logic [NR-1:0] exp_ready;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NR; k++) exp_ready[k] = !m_pend[k];
        chk("ready", 64'(req_ready), 64'(exp_ready));
        chk("valid", 64'(mem_valid), 64'(m_valid));
        if (m_valid) begin
            chk("addr", 64'(mem_addr), 64'(m_oaddr));
            chk("data", 64'(mem_data), 64'(m_odata));
            chk("we",   64'(mem_we),   64'(m_owe));
            chk("id",   64'(mem_id),   64'(m_oid));
            chk("we_nonzero", 64'(mem_we != 4'b0000), 64'd1);
        end
`ifdef STORE_PORT_ARB_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
        chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] w);
        req_valid[k]        = 1'b1;
        req_addr[k*32 +: 32] = a;
        req_data[k*32 +: 32] = d;
        req_we[k*4 +: 4]     = w;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_we    = '0;
        mem_ready = 1'b1;

        // Reset state
        step();
        chk("rst_ready", 64'(req_ready), 64'hF);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        reset = 1'b0;
        step();

        // Single store from requester 2
        set_req(2, 32'h0000_0104, 32'h0000_AB00, 4'b0010);
        step();
        req_valid = '0;
        chk("single_ready2_low", 64'(req_ready[2]), 64'd0);
        chk("single_not_yet", 64'(mem_valid), 64'd0);
        step();
        chk("single_valid", 64'(mem_valid), 64'd1);
        chk("single_id",    64'(mem_id),    64'd2);
        chk("single_addr",  64'(mem_addr),  64'h0000_0104);
        chk("single_data",  64'(mem_data),  64'h0000_AB00);
        chk("single_we",    64'(mem_we),    64'b0010);
        chk("single_ready2_back", 64'(req_ready[2]), 64'd1);
        step();
        chk("single_one_beat", 64'(mem_valid), 64'd0);

        // All-request round-robin after reset, requesters keep re-requesting
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < NR; k++) set_req(k, 32'h1000_0000 + 32'(k * 16), 32'hC0DE_0000 + 32'(k), 4'b1111);
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_valid", 64'(mem_valid), 64'd1);
            chk("rr_order", 64'(mem_id), 64'(i % NR));
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) step();

        // Backpressure with beat from requester 1
        set_req(1, 32'h2000_0010, 32'h1234_5678, 4'b1111);
        step();
        req_valid = '0;
        mem_ready = 1'b0;
        step();
        chk("bp_loaded_id", 64'(mem_id), 64'd1);
        set_req(0, 32'h3000_0000, 32'hAAAA_0000, 4'b0011);
        set_req(3, 32'h3000_0030, 32'hBBBB_0000, 4'b1100);
        for (int i = 0; i < 5; i++) begin
            step();
            req_valid = '0;
            chk("bp_hold_valid", 64'(mem_valid), 64'd1);
            chk("bp_hold_id",    64'(mem_id),    64'd1);
            chk("bp_hold_addr",  64'(mem_addr),  64'h2000_0010);
            chk("bp_hold_data",  64'(mem_data),  64'h1234_5678);
        end
        chk("bp_accepted_0_3", 64'(req_ready), 64'b0110);
        mem_ready = 1'b1;
        step();
        chk("bp_first_id", 64'(mem_id), 64'd3);
        step();
        chk("bp_second_id", 64'(mem_id), 64'd0);
        for (int i = 0; i < 3; i++) step();

        // Zero byte-enable store then a full-word store from requester 0
        set_req(0, 32'h4000_0000, 32'hDEAD_BEEF, 4'b0000);
        step();
        chk("zwe_ready_kept", 64'(req_ready[0]), 64'd1);
        set_req(0, 32'h4000_0004, 32'hFEED_F00D, 4'b1111);
        step();
        req_valid = '0;
        chk("zwe_no_beat", 64'(mem_valid), 64'd0);
        step();
        chk("zwe_beat_we", 64'(mem_we), 64'b1111);
        step();
        chk("zwe_single_beat", 64'(mem_valid), 64'd0);

        // Reset with three entries pending and a beat held
        mem_ready = 1'b0;
        for (int k = 0; k < NR; k++) set_req(k, 32'h5000_0000 + 32'(k * 4), 32'h5555_0000 + 32'(k), 4'b0101);
        step();
        req_valid = '0;
        step();
        chk("mid_valid_before", 64'(mem_valid), 64'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'hF);
        reset     = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < NR; k++) set_req(k, 32'h6000_0000 + 32'(k * 4), 32'h6666_0000 + 32'(k), 4'b1010);
        step();
        req_valid = '0;
        step();
        chk("mid_first_grant", 64'(mem_id), 64'd0);
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) begin
                req_valid[k]         = ($urandom_range(0, 1) == 1);
                req_addr[k*32 +: 32] = $urandom;
                req_data[k*32 +: 32] = $urandom;
                req_we[k*4 +: 4]     = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_port_arbiter.md
Name: store_port_arbiter

Overview:
- Shares the single data-memory write port between NUM_REQ store requesters, such as per-hart store units or a store unit and a debug/DMA writer.
- Each requester presents an already-aligned store: a word address, data shifted to its lanes, and a 4-bit byte-enable mask.
- The block buffers one store per requester, picks one per cycle round-robin, and drives a registered valid/ready memory write channel.
- It sits between the execute-stage store formatting logic and the data BRAM write port.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2..8.
- ADDR_W, 32, byte address width; bits [1:0] are forwarded unchanged.
- ID_W, 3, width of the requester index on the output; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req_valid  input  NUM_REQ  per-requester store request.
- o_req_ready  output  NUM_REQ  per-requester accept. Registered; equals NOT pending[k].
- i_req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- i_req_data  input  NUM_REQ*32  packed lane-aligned write data.
- i_req_we  input  NUM_REQ*4  packed byte enables.
- o_mem_valid  output  1  write beat valid.
- i_mem_ready  input  1  memory accepts the beat.
- o_mem_addr  output  ADDR_W  granted address.
- o_mem_data  output  32  granted data.
- o_mem_we  output  4  granted byte enables; never 0 while o_mem_valid is high.
- o_mem_id  output  ID_W  index of the granted requester.
- o_stall_cnt  output  32  stall counter; see Optional Feature.

Behaviour:
- Handshake, request side: a request is accepted at a rising edge where i_req_valid[k] and o_req_ready[k] are both high. Its addr, data and we are captured into hold register k and pending[k] is set. While pending[k] is set, o_req_ready[k] is low.
- Zero byte-enable store: a request with we == 4'b0000 is still accepted. Hold register k and pending[k] are not written, and nothing is ever forwarded for it.
- Output stage load condition: the output stage is free when (NOT o_mem_valid) OR i_mem_ready.
- Output stage load: if the output stage is free and any pending bit is set, the stage loads the winner's addr/data/we/id and sets o_mem_valid. The same edge clears pending[winner].
- Output stage drain: if the output stage is free and no pending bit is set, o_mem_valid goes low.
- Hold: while o_mem_valid is high and i_mem_ready is low, every output holds stable.
- Arbitration: round-robin over the pending bits. The search starts at pointer ptr and increments mod NUM_REQ. After a load of winner k, ptr becomes (k+1) mod NUM_REQ. ptr does not change when nothing is loaded.
- Latency: a request accepted at edge E0 appears on o_mem_valid after edge E1 at the earliest (one cycle). o_req_ready[k] returns high after the edge that loads it into the output stage.
- Throughput: one beat per cycle while i_mem_ready stays high and pending requests exist.
- Same-edge load and re-capture: a requester's pending bit can be cleared and re-set on the same edge only if ready was already high. Since ready = NOT pending, no same-cycle re-capture is possible. Back-to-back stores from one requester therefore issue every 2 cycles.
- Reset: pending = 0 and ptr = 0. o_mem_valid = 0 and o_mem_addr/data/we/id = 0. o_req_ready = all ones from the first cycle after reset deasserts. o_stall_cnt = 0.
- Reset mid-operation: any held or in-flight beat is dropped; the memory side must ignore o_mem_valid during reset.
- Request side while i_mem_ready is low: requesters without a pending entry keep being accepted.

Optional Feature:
- Macro: STORE_PORT_ARB_STALL_CNT_EN.
- Defined: o_stall_cnt increments by 1 on every edge where o_mem_valid = 1 and i_mem_ready = 0. It saturates at 32'hFFFF_FFFF and clears on reset.
- Not defined: o_stall_cnt is the constant 0 and no counter flops are synthesised. The port list is identical in both builds.

Test Plan:
- Single store: requester 2 sends addr 0x0000_0104, data 0x0000_AB00, we 4'b0010, with i_mem_ready = 1. Required: o_mem_valid for exactly 1 cycle, one cycle after acceptance, with id = 2 and the same addr/data/we. o_req_ready[2] is low for that single cycle.
- All-request round-robin: all 4 requesters raise valid after reset and i_mem_ready = 1. Required: grants in order 0,1,2,3. Requesters re-requesting continuously then get grants 0,1,2,3 repeating with no starvation.
- Backpressure: one beat is valid from requester 1 and i_mem_ready is held low for 5 cycles. Required: outputs stable for all 5 cycles, and requesters 0 and 3 are still accepted. After i_mem_ready rises, beats follow as 3 then 0 (ptr = 2). With STORE_PORT_ARB_STALL_CNT_EN defined, o_stall_cnt = 5.
- Zero byte-enable store: requester 0 sends we = 4'b0000 followed by we = 4'b1111. Required: only one beat is issued (we 4'b1111), and o_req_ready[0] never drops for the first request.
- Reset mid-operation: reset is asserted with 3 entries pending and o_mem_valid high. Required: after the reset edge, o_mem_valid = 0 and o_req_ready = 4'b1111. The first post-reset grant goes to requester 0 when all requesters request.
